// File: rtl/branch_predictor.sv
// branch_predictor: dynamic branch predictor with a 2-bit counter BHT and a tagged direct-mapped BTB
//   Build option: define BP_GSHARE_EN to XOR a global history register into the BHT index.
//   Ports:
//     clk, rst_n                 clock (rising edge), asynchronous active-low reset
//     if_pc                      fetch PC
//     pred_taken, pred_target    combinational prediction for if_pc
//     ex_valid, ex_pc,
//     ex_br_type, ex_taken,
//     ex_target, ex_pred_taken,
//     ex_pred_target             resolved control-flow instruction in EX, with its carried prediction
//     mispredict, redirect_pc    combinational redirect request and correct next PC
//     br_cnt, miss_cnt           resolved branch/jump count and mispredict count
//   Branch type codes: 0 none, 1..6 BEQ/BNE/BLT/BGE/BLTU/BGEU, 7 JAL, 8 JALR, 9..15 none.
module branch_predictor #(
  parameter int         BHT_DEPTH = 64,
  parameter int         BTB_DEPTH = 16,
  parameter logic [1:0] CNT_INIT  = 2'b01,
  parameter int         GHR_W     = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  ex_br_type,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);
  localparam int BI_W  = $clog2(BHT_DEPTH);
  localparam int TI_W  = $clog2(BTB_DEPTH);
  localparam int TAG_W = 30 - TI_W;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BGEU = 4'd6;
  localparam logic [3:0] BR_JAL  = 4'd7;
  localparam logic [3:0] BR_JALR = 4'd8;

  logic [1:0]       bht_q     [BHT_DEPTH];
  logic             btb_v_q   [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag_q [BTB_DEPTH];
  logic [31:0]      btb_tgt_q [BTB_DEPTH];
  logic             btb_unc_q [BTB_DEPTH];
  logic [31:0]      br_cnt_q, miss_cnt_q, br_cnt_d, miss_cnt_d;
  logic [BI_W-1:0]  hist, bi_if, bi_ex;
  logic [TI_W-1:0]  ti_if, ti_ex;
  logic [1:0]       cnt_ex, cnt_d;
  logic             hit, is_cond, is_br, upd;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;
  assign hist  = BI_W'(ghr_q);
  assign ghr_d = {ghr_q[GHR_W-2:0], ex_taken};
  // History advances only on conditional branches; the EX index above uses the pre-shift value.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ghr_q <= '0;
    else if (upd && is_cond) ghr_q <= ghr_d;
`else
  assign hist = '0;
`endif

  assign bi_if = if_pc[BI_W+1:2] ^ hist;
  assign bi_ex = ex_pc[BI_W+1:2] ^ hist;
  assign ti_if = if_pc[TI_W+1:2];
  assign ti_ex = ex_pc[TI_W+1:2];

  assign hit         = btb_v_q[ti_if] && btb_tag_q[ti_if] == if_pc[31:TI_W+2];
  assign pred_taken  = hit && (btb_unc_q[ti_if] || bht_q[bi_if][1]);
  assign pred_target = pred_taken ? btb_tgt_q[ti_if] : if_pc + 32'd4;

  assign is_cond     = ex_br_type >= BR_BEQ && ex_br_type <= BR_BGEU;
  assign is_br       = is_cond || ex_br_type == BR_JAL || ex_br_type == BR_JALR;
  assign upd         = ex_valid && is_br;
  assign mispredict  = upd && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  assign br_cnt      = br_cnt_q;
  assign miss_cnt    = miss_cnt_q;

  always_comb begin
    cnt_ex     = bht_q[bi_ex];
    cnt_d      = ex_taken ? (cnt_ex == 2'd3 ? cnt_ex : cnt_ex + 2'd1)
                          : (cnt_ex == 2'd0 ? cnt_ex : cnt_ex - 2'd1);
    br_cnt_d   = br_cnt_q + 32'd1;
    miss_cnt_d = miss_cnt_q + 32'(mispredict);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CNT_INIT;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_unc_q[i] <= 1'b0;
      end
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (upd) begin
      if (is_cond) bht_q[bi_ex] <= cnt_d;
      // Taken outcomes always (re)allocate, evicting any aliasing entry.
      if (ex_taken) begin
        btb_v_q[ti_ex]   <= 1'b1;
        btb_tag_q[ti_ex] <= ex_pc[31:TI_W+2];
        btb_tgt_q[ti_ex] <= ex_target;
        btb_unc_q[ti_ex] <= !is_cond;
      end
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized and directed checks of branch_predictor against a table-level model
module tb_branch_predictor;
  logic        clk = 0, rst_n = 0;
  logic [31:0] if_pc = 0, ex_pc = 0, ex_target = 0, ex_pred_target = 0;
  logic [3:0]  ex_br_type = 0;
  logic        ex_valid = 0, ex_taken = 0, ex_pred_taken = 0;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, br_cnt, miss_cnt;
  int checks = 0, errors = 0;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_type(ex_br_type), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: counters per BHT slot, BTB remembers the full PC of the last taken branch.
  int          m_cnt [64];
  bit          m_v   [16];
  logic [31:0] m_pc  [16];
  logic [31:0] m_tgt [16];
  bit          m_unc [16];
  logic [31:0] m_br, m_miss;
  int          m_ghr;

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
    m_br = 0; m_miss = 0; m_ghr = 0;
  endfunction

  function automatic int bidx(logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return int'((pc >> 2) % 64) ^ m_ghr;
`else
    return int'((pc >> 2) % 64);
`endif
  endfunction

  function automatic bit m_pt(logic [31:0] pc);
    int t = int'((pc >> 2) % 16);
    bit h = m_v[t] && (m_pc[t] >> 6) == (pc >> 6);
    return h && (m_unc[t] || m_cnt[bidx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptg(logic [31:0] pc);
    return m_pt(pc) ? m_tgt[(pc >> 2) % 16] : pc + 4;
  endfunction

  function automatic bit m_mis(logic [3:0] ty, bit tk, logic [31:0] tg, bit pt, logic [31:0] ptg);
    if (ty < 1 || ty > 8) return 0;
    return tk != pt || (tk && tg != ptg);
  endfunction

  function automatic void m_update(logic [31:0] pc, logic [3:0] ty, bit tk, logic [31:0] tg, bit pt, logic [31:0] ptg);
    int b, t;
    if (ty < 1 || ty > 8) return;
    b = bidx(pc);
    t = int'((pc >> 2) % 16);
    if (ty <= 6) begin
      m_cnt[b] = tk ? (m_cnt[b] < 3 ? m_cnt[b] + 1 : 3) : (m_cnt[b] > 0 ? m_cnt[b] - 1 : 0);
      m_ghr = ((m_ghr << 1) | int'(tk)) % 64;
    end
    if (tk) begin
      m_v[t] = 1; m_pc[t] = pc; m_tgt[t] = tg; m_unc[t] = ty > 6;
    end
    m_miss += 32'(m_mis(ty, tk, tg, pt, ptg));
    m_br += 1;
  endfunction

  logic        o_mis;
  logic [31:0] o_red;

  task automatic exec(input logic [31:0] pc, input logic [3:0] ty, input logic tk, input logic [31:0] tg,
                      input logic pt, input logic [31:0] ptg);
    @(negedge clk);
    ex_valid = 1; ex_pc = pc; ex_br_type = ty; ex_taken = tk; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg;
    #1;
    o_mis = mispredict; o_red = redirect_pc;
    @(posedge clk);
    m_update(pc, ty, tk, tg, pt, ptg);
    #1 ex_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; m_reset();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    if_pc = 32'h1000; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h1004) begin errors++;
      $display("FAIL reset_pred got %b/%h want 0/00001004", pred_taken, pred_target); end
    checks++; if (br_cnt !== 0 || miss_cnt !== 0) begin errors++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", br_cnt, miss_cnt); end
  endtask

  task automatic test_first_taken();
    logic em;
    em = m_mis(1, 1, 32'h0F00, 0, 32'h1004);
    exec(32'h1000, 1, 1, 32'h0F00, 0, 32'h1004);
    checks++; if (o_mis !== em || o_red !== 32'h0F00) begin errors++;
      $display("FAIL beq_mis got %b/%h want %b/00000f00", o_mis, o_red, em); end
    checks++; if (miss_cnt !== m_miss || m_miss !== 1) begin errors++;
      $display("FAIL beq_miss_cnt got %0d want 1", miss_cnt); end
    @(negedge clk); if_pc = 32'h1000; #1;
    checks++; if (pred_taken !== m_pt(if_pc) || pred_target !== m_ptg(if_pc)) begin errors++;
      $display("FAIL beq_pred got %b/%h want %b/%h", pred_taken, pred_target, m_pt(if_pc), m_ptg(if_pc)); end
`ifndef BP_GSHARE_EN
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h0F00) begin errors++;
      $display("FAIL beq_pred_const got %b/%h want 1/00000f00", pred_taken, pred_target); end
`endif
  endtask

  task automatic test_saturate();
    bit exp_pt [5] = '{1, 1, 1, 1, 0};
    bit seq [5] = '{1, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      exec(32'h2000, 2, seq[i], 32'h2100, m_pt(32'h2000), m_ptg(32'h2000));
      @(negedge clk); if_pc = 32'h2000; #1;
      checks++; if (pred_taken !== m_pt(if_pc)) begin errors++;
        $display("FAIL bne_step%0d got %b want %b", i, pred_taken, m_pt(if_pc)); end
`ifndef BP_GSHARE_EN
      checks++; if (pred_taken !== exp_pt[i]) begin errors++;
        $display("FAIL bne_const%0d got %b want %b", i, pred_taken, exp_pt[i]); end
`endif
    end
  endtask

  task automatic test_alias();
    exec(32'h3000, 7, 1, 32'h4000, 0, 32'h3004);
    @(negedge clk); if_pc = 32'h3000; #1;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h4000) begin errors++;
      $display("FAIL jal_pred got %b/%h want 1/00004000", pred_taken, pred_target); end
    exec(32'h3040, 1, 1, 32'h5000, 0, 32'h3044);
    @(negedge clk); if_pc = 32'h3000; #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h3004) begin errors++;
      $display("FAIL alias_evict got %b/%h want 0/00003004", pred_taken, pred_target); end
    if_pc = 32'h3040; #1;
    checks++; if (pred_taken !== m_pt(if_pc) || pred_target !== m_ptg(if_pc)) begin errors++;
      $display("FAIL alias_new got %b/%h want %b/%h", pred_taken, pred_target, m_pt(if_pc), m_ptg(if_pc)); end
  endtask

  task automatic test_not_branch();
    logic [31:0] b0, m0;
    b0 = br_cnt; m0 = miss_cnt;
    exec(32'h1000, 0, 1, 32'h7000, 0, 32'h1004);
    checks++; if (o_mis !== 1'b0 || o_red !== 32'h7000) begin errors++;
      $display("FAIL nobr_mis got %b/%h want 0/00007000", o_mis, o_red); end
    checks++; if (br_cnt !== b0 || miss_cnt !== m0 || br_cnt !== m_br) begin errors++;
      $display("FAIL nobr_cnt got %0d/%0d want %0d/%0d", br_cnt, miss_cnt, b0, m0); end
    @(negedge clk); if_pc = 32'h1000; #1;
    checks++; if (pred_taken !== m_pt(if_pc) || pred_target !== m_ptg(if_pc)) begin errors++;
      $display("FAIL nobr_pred got %b/%h want %b/%h", pred_taken, pred_target, m_pt(if_pc), m_ptg(if_pc)); end
  endtask

  task automatic test_random();
    logic [31:0] pool [8] = '{32'h1000, 32'h1040, 32'h2000, 32'h2004, 32'h3000, 32'h3040, 32'h10000, 32'h0};
    logic [31:0] pc, tg, ptg; logic [3:0] ty; bit tk, pt, em;
    for (int i = 0; i < 300; i++) begin
      pool[7] = $urandom() & 32'hFFFF_FFFC;
      pc = pool[$urandom_range(0, 7)];
      ty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) ty = 4'($urandom_range(1, 8));
      tk = 1'($urandom_range(0, 1));
      tg = 32'h8000 + 32'($urandom_range(0, 3)) * 32'h100;
      pt = m_pt(pc); ptg = m_ptg(pc);
      if ($urandom_range(0, 3) == 0) begin pt = 1'($urandom_range(0, 1)); ptg = tg; end
      em = m_mis(ty, tk, tg, pt, ptg);
      exec(pc, ty, tk, tg, pt, ptg);
      checks++; if (o_mis !== em || o_red !== (tk ? tg : pc + 4)) begin errors++;
        $display("FAIL rnd_mis%0d got %b/%h want %b/%h", i, o_mis, o_red, em, tk ? tg : pc + 4); end
      @(negedge clk); if_pc = pool[$urandom_range(0, 6)]; #1;
      checks++; if (pred_taken !== m_pt(if_pc) || pred_target !== m_ptg(if_pc)) begin errors++;
        $display("FAIL rnd_pred%0d pc %h got %b/%h want %b/%h", i, if_pc, pred_taken, pred_target, m_pt(if_pc), m_ptg(if_pc)); end
      checks++; if (br_cnt !== m_br || miss_cnt !== m_miss) begin errors++;
        $display("FAIL rnd_cnt%0d got %0d/%0d want %0d/%0d", i, br_cnt, miss_cnt, m_br, m_miss); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_valid = 1; ex_pc = 32'h3000; ex_br_type = 7; ex_taken = 1; ex_target = 32'h9000;
    ex_pred_taken = 0; ex_pred_target = 32'h3004; if_pc = 32'h3000;
    #2 rst_n = 0; m_reset(); #1;
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h3004 || br_cnt !== 0 || miss_cnt !== 0) begin errors++;
      $display("FAIL rst_mid got %b/%h/%0d/%0d want 0/00003004/0/0", pred_taken, pred_target, br_cnt, miss_cnt); end
    checks++; if (mispredict !== 1'b1) begin errors++;
      $display("FAIL rst_mid_mis got %b want 1", mispredict); end
    @(posedge clk); #1;
    checks++; if (pred_taken !== 1'b0 || br_cnt !== 0) begin errors++;
      $display("FAIL rst_hold got %b/%0d want 0/0", pred_taken, br_cnt); end
    @(negedge clk); ex_valid = 0; rst_n = 1;
  endtask

  task automatic test_alternating();
    logic [31:0] late;
    do_reset();
    late = 0;
    for (int i = 0; i < 48; i++) begin
      exec(32'h1000, 1, 1'(i % 2 == 0), 32'h0F00, m_pt(32'h1000), m_ptg(32'h1000));
      if (i >= 32) late += 32'(o_mis);
    end
    checks++; if (miss_cnt !== m_miss || br_cnt !== 48) begin errors++;
      $display("FAIL alt_cnt got %0d/%0d want %0d/48", miss_cnt, br_cnt, m_miss); end
`ifdef BP_GSHARE_EN
    checks++; if (late !== 0) begin errors++;
      $display("FAIL alt_gshare_late got %0d want 0", late); end
`else
    checks++; if (late === 0) begin errors++;
      $display("FAIL alt_pc_late got %0d want nonzero", late); end
`endif
  endtask

  initial begin
    m_reset();
    test_reset();
    test_first_taken();
    test_saturate();
    test_alias();
    test_not_branch();
    test_random();
    test_reset_mid();
    test_alternating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
